// File: rtl/multi_channel_timer_pkg.sv
// Shared encodings for multi_channel_timer: channel states, mode and tick-select constants.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam logic SEL_CLK  = 1'b0;
    localparam logic SEL_TICK = 1'b1;

endpackage

// File: rtl/multi_channel_timer_prescaler.sv
// Free-running prescaler producing a one-cycle clock-enable tick every CLK_DIV cycles.
module tick_prescaler #(
    parameter int CLK_DIV = 25000,
    parameter int DIV_W   = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // With CLK_DIV = 1 the counter sits at 0 and the tick stays high.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_q == DIV_LAST);
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent start/stop timers sharing one prescaler tick.
// Optional per-channel pause input enabled by defining MULTI_CHANNEL_TIMER_PAUSE_EN.
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int NUM_CH  = 2,
    parameter int CLK_DIV = 25000,
    parameter int DIV_W   = 15
) (
    input  logic                    clk_50M,
    input  logic                    i_Reset,
    input  logic [NUM_CH-1:0]       i_Clear,
    input  logic [NUM_CH-1:0]       i_Start,
    input  logic [NUM_CH-1:0]       i_Stop,
    input  logic [NUM_CH-1:0]       i_Mode,
    input  logic [NUM_CH-1:0]       i_TickSel,
    input  logic [NUM_CH*WIDTH-1:0] i_Limit,
`ifdef MULTI_CHANNEL_TIMER_PAUSE_EN
    input  logic [NUM_CH-1:0]       i_Pause,
`endif
    output logic [NUM_CH*WIDTH-1:0] o_Count,
    output logic [NUM_CH-1:0]       o_Busy,
    output logic [NUM_CH-1:0]       o_Done,
    output logic                    o_Tick
);

    logic              tick;
    logic [NUM_CH-1:0] pause;

`ifdef MULTI_CHANNEL_TIMER_PAUSE_EN
    assign pause = i_Pause;
`else
    assign pause = '0;
`endif

    tick_prescaler #(
        .CLK_DIV(CLK_DIV),
        .DIV_W  (DIV_W)
    ) u_prescaler (
        .clk_i (clk_50M),
        .rst_i (i_Reset),
        .tick_o(tick)
    );

    assign o_Tick = tick;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_e           state_q, state_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] limit_q, limit_d;
        logic             mode_q, mode_d;
        logic             sel_q, sel_d;
        logic             done_q, done_d;
        logic [WIDTH-1:0] lim_in;
        logic [WIDTH-1:0] count_inc;
        logic             en;
        logic             last;
        logic             busy;

        assign lim_in = i_Limit[k*WIDTH +: WIDTH];

        always_ff @(posedge clk_50M or posedge i_Reset) begin
            if (i_Reset) begin
                state_q <= IDLE;
                count_q <= '0;
                limit_q <= '0;
                mode_q  <= MODE_ONESHOT;
                sel_q   <= SEL_CLK;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                limit_q <= limit_d;
                mode_q  <= mode_d;
                sel_q   <= sel_d;
                done_q  <= done_d;
            end
        end

        // Clear beats Stop beats Start beats counting; a restart never emits Done.
        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            limit_d   = limit_q;
            mode_d    = mode_q;
            sel_d     = sel_q;
            done_d    = 1'b0;
            en        = (sel_q == SEL_TICK) ? tick : 1'b1;
            count_inc = count_q + WIDTH'(1);
            last      = (limit_q == '0) || (count_inc == limit_q);

            if (i_Clear[k]) begin
                state_d = IDLE;
                count_d = '0;
            end else if (i_Stop[k]) begin
                state_d = IDLE;
            end else if (i_Start[k]) begin
                count_d = '0;
                limit_d = lim_in;
                mode_d  = i_Mode[k];
                sel_d   = i_TickSel[k];
                // A zero limit terminates immediately on the start itself.
                done_d  = (lim_in == '0);
                state_d = ((lim_in == '0) && (i_Mode[k] == MODE_ONESHOT)) ? HOLD : RUN;
            end else if ((state_q == RUN) && en && !pause[k]) begin
                if (last) begin
                    done_d = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        count_d = '0;
                    end else begin
                        count_d = limit_q;
                        state_d = HOLD;
                    end
                end else begin
                    count_d = count_inc;
                end
            end
        end

        always_comb begin
            busy = (state_q == RUN);
        end

        assign o_Count[k*WIDTH +: WIDTH] = count_q;
        assign o_Busy[k]                 = busy;
        assign o_Done[k]                 = done_q;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer (CLK_DIV=4, WIDTH=12, NUM_CH=2).
module tb_multi_channel_timer;
    import timer_pkg::*;

    localparam int W  = 12;
    localparam int NC = 2;
    localparam int DV = 4;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   clr, start, stop, mode, sel, pause;
    logic [NC*W-1:0] limit;
    logic [NC*W-1:0] count;
    logic [NC-1:0]   busy, done;
    logic            tick;

    int   cyc = 0;
    int   r = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[NC][$];

    multi_channel_timer #(
        .WIDTH  (W),
        .NUM_CH (NC),
        .CLK_DIV(DV),
        .DIV_W  (3)
    ) dut (
        .clk_50M  (clk),
        .i_Reset  (rst),
        .i_Clear  (clr),
        .i_Start  (start),
        .i_Stop   (stop),
        .i_Mode   (mode),
        .i_TickSel(sel),
        .i_Limit  (limit),
`ifdef MULTI_CHANNEL_TIMER_PAUSE_EN
        .i_Pause  (pause),
`endif
        .o_Count  (count),
        .o_Busy   (busy),
        .o_Done   (done),
        .o_Tick   (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d expected finish before limit", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int cnt(input int k);
        return int'(count[k*W +: W]);
    endfunction

    // Tick model: after release at cycle r, o_Tick is high in cycles r+4, r+8, ...
    function automatic int next_tick(input int c);
        if (c <= r) return r + DV;
        return c + ((DV - ((c - r) % DV)) % DV);
    endfunction

    task automatic start_ch(input int k, input logic m, input logic s_sel,
                            input int lim, output int s);
        mode[k]          = m;
        sel[k]           = s_sel;
        limit[k*W +: W]  = W'(lim);
        start[k]         = 1'b1;
        s                = cyc;
        wait_cyc(s + 1);
        start[k]         = 1'b0;
    endtask

    task automatic push(input int k, input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.cnt = v;
        q[k].push_back(e);
    endtask

    // Monitor: every Done pulse must match the head of that channel's queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NC; k++) begin
                    if (done[k]) begin
                        checks++;
                        if (q[k].size() == 0) begin
                            errors++;
                            $display("FAIL done_unexpected ch%0d cyc=%0d count=%0d expected no pulse",
                                     k, cyc, cnt(k));
                        end else begin
                            e = q[k].pop_front();
                            if (e.cyc != cyc || e.cnt != cnt(k)) begin
                                errors++;
                                $display("FAIL done_ch%0d actual cyc=%0d count=%0d expected cyc=%0d count=%0d",
                                         k, cyc, cnt(k), e.cyc, e.cnt);
                            end
                        end
                    end else if (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
                        checks++;
                        errors++;
                        e = q[k].pop_front();
                        $display("FAIL done_missing ch%0d actual no pulse by cyc=%0d expected cyc=%0d count=%0d",
                                 k, cyc, e.cyc, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int s, c, t1, t2;
        rst   = 1'b1;
        clr   = '0;
        start = '0;
        stop  = '0;
        mode  = '0;
        sel   = '0;
        pause = '0;
        limit = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_count", int'(count), 0);
        check("reset_busy_done_tick", int'({busy, done, tick}), 0);
        rst = 1'b0;
        r   = cyc;

        // Reset mid-run: outputs clear immediately, prescaler restarts.
        start_ch(0, MODE_ONESHOT, SEL_CLK, 100, s);
        check("start_busy", int'(busy[0]), 1);
        check("start_count0", cnt(0), 0);
        wait_cyc(s + 6);
        check("midrun_count5", cnt(0), 5);
        rst = 1'b1;
        #2;
        check("async_reset_count", int'(count), 0);
        check("async_reset_busy_done_tick", int'({busy, done, tick}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
        for (int i = 1; i <= 4; i++) begin
            wait_cyc(r + i);
            @(negedge clk);
            check("tick_after_reset", int'(tick), (i == 4) ? 1 : 0);
        end

        // One-shot on prescaler tick, limit 3.
        start_ch(0, MODE_ONESHOT, SEL_TICK, 3, s);
        t1 = next_tick(s + 1);
        push(0, t1 + 2 * DV + 1, 3);
        wait_cyc(t1 + 1);
        check("oneshot_tick_count1", cnt(0), 1);
        wait_cyc(t1 + DV + 1);
        check("oneshot_tick_count2", cnt(0), 2);
        wait_cyc(t1 + 2 * DV + 2);
        check("oneshot_hold_count", cnt(0), 3);
        check("oneshot_hold_busy", int'(busy[0]), 0);

        // Periodic on clk, limit 5: Done every 5 cycles, ch0 untouched.
        c = cyc;
        for (int i = 0; i < 4; i++) push(1, c + 6 + 5 * i, 0);
        start_ch(1, MODE_PERIODIC, SEL_CLK, 5, s);
        wait_cyc(s + 3);
        check("periodic_count2", cnt(1), 2);
        wait_cyc(s + 10);
        check("ch0_isolated_count", cnt(0), 3);
        check("ch0_isolated_busy", int'(busy[0]), 0);
        wait_cyc(s + 21);
        stop[1] = 1'b1;
        wait_cyc(s + 22);
        stop[1] = 1'b0;
        check("periodic_stop_busy", int'(busy[1]), 0);

        // Limit 0, one-shot: Done in n+1 with count 0, then HOLD.
        push(0, cyc + 1, 0);
        start_ch(0, MODE_ONESHOT, SEL_CLK, 0, s);
        wait_cyc(s + 2);
        check("lim0_oneshot_busy", int'(busy[0]), 0);
        check("lim0_oneshot_count", cnt(0), 0);

        // Limit 0, periodic: Done every cycle.
        c = cyc;
        for (int i = 1; i <= 5; i++) push(1, c + i, 0);
        start_ch(1, MODE_PERIODIC, SEL_CLK, 0, s);
        wait_cyc(s + 5);
        stop[1] = 1'b1;
        wait_cyc(s + 6);
        stop[1] = 1'b0;
        check("lim0_periodic_busy", int'(busy[1]), 0);

        // Clear and Start together: Clear wins.
        start_ch(0, MODE_ONESHOT, SEL_CLK, 50, s);
        wait_cyc(s + 4);
        clr[0]   = 1'b1;
        start[0] = 1'b1;
        wait_cyc(s + 5);
        clr[0]   = 1'b0;
        start[0] = 1'b0;
        check("clear_start_busy", int'(busy[0]), 0);
        check("clear_start_count", cnt(0), 0);

        // Start on the terminal cycle: restart, no Done for the aborted run.
        start_ch(0, MODE_PERIODIC, SEL_CLK, 4, s);
        wait_cyc(s + 4);
        check("pre_terminal_count", cnt(0), 3);
        push(0, s + 9, 0);
        start[0] = 1'b1;
        wait_cyc(s + 5);
        start[0] = 1'b0;
        check("restart_count", cnt(0), 0);
        check("restart_busy", int'(busy[0]), 1);

        // Stop at count 2: IDLE, count held.
        wait_cyc(s + 11);
        check("pre_stop_count", cnt(0), 2);
        stop[0] = 1'b1;
        wait_cyc(s + 12);
        stop[0] = 1'b0;
        check("stop_busy", int'(busy[0]), 0);
        check("stop_count", cnt(0), 2);
        wait_cyc(s + 14);
        check("stop_count_held", cnt(0), 2);

`ifdef MULTI_CHANNEL_TIMER_PAUSE_EN
        // Pause for 8 ticks at count 2 delays Done by 8 ticks.
        start_ch(0, MODE_ONESHOT, SEL_TICK, 5, s);
        t1 = next_tick(s + 1);
        t2 = t1 + DV;
        push(0, t1 + 12 * DV + 1, 5);
        wait_cyc(t2 + 1);
        check("pause_entry_count", cnt(0), 2);
        pause[0] = 1'b1;
        wait_cyc(t2 + 20);
        check("paused_count", cnt(0), 2);
        check("paused_busy", int'(busy[0]), 1);
        wait_cyc(t2 + 33);
        pause[0] = 1'b0;
        wait_cyc(t2 + 50);
        check("pause_final_count", cnt(0), 5);
`endif

        wait_cyc(cyc + 40);
        for (int k = 0; k < NC; k++) check("scoreboard_drained", q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
